// File: rtl/otter_intc.sv
// otter_intc: multi-source interrupt controller for the OTTER MCU, mapped on the IOBUS.
//
// Each source has its own enable, edge/level mode and pending bit. The controller drives
// one registered INTR line, and the handler finds the source by reading the ID register.
//
// Ports:
//   CLK         system clock
//   RST_N       asynchronous active-low reset
//   SRC         raw interrupt requests (asynchronous to CLK, active-high)
//   IOBUS_ADDR  MCU IO byte address; the block is selected when [31:5] matches BASE_ADDR
//   IOBUS_OUT   MCU write data
//   IOBUS_WR    MCU IO write strobe
//   IOBUS_IN    registered read data (shows the address presented on the previous cycle)
//   INTR        registered interrupt request = GIE & |(PENDING & ENABLE)
//
// Register map (word offsets):
//   0x00 PENDING  read; write-1-to-clear (edge-mode bits only)
//   0x04 ENABLE   RW
//   0x08 EDGE     RW, 1 = rising edge, 0 = level; any write clears PENDING
//   0x0C ID       RO, bit31 = valid, bits[3:0] = winning source
//   0x10 GIE      RW, bit0
//   0x14 PRIO     RW, 2 bits per source     (OTTER_INTC_PRIORITY_EN only)
//   0x18 THRESH   RW, 2 bits                (OTTER_INTC_PRIORITY_EN only)
//
// Build option: define OTTER_INTC_PRIORITY_EN to add the PRIO/THRESH registers and
// priority arbitration. Without it the lowest active index wins and there is no threshold.
module otter_intc #(
  parameter int unsigned NUM_SRC     = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] SRC,
  input  logic [31:0]        IOBUS_ADDR,
  input  logic [31:0]        IOBUS_OUT,
  input  logic               IOBUS_WR,
  output logic [31:0]        IOBUS_IN,
  output logic               INTR
);

  localparam logic [4:0] OffPending = 5'h00;
  localparam logic [4:0] OffEnable  = 5'h04;
  localparam logic [4:0] OffEdge    = 5'h08;
  localparam logic [4:0] OffId      = 5'h0C;
  localparam logic [4:0] OffGie     = 5'h10;
`ifdef OTTER_INTC_PRIORITY_EN
  localparam logic [4:0] OffPrio    = 5'h14;
  localparam logic [4:0] OffThresh  = 5'h18;
`endif

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] hist_q;
  logic [NUM_SRC-1:0] synced;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] act;
  logic [NUM_SRC-1:0] w1c;
  logic               gie_q, gie_d;
  logic               intr_d;
  logic [31:0]        rdata_d;
  logic               sel;
  logic               wr_en;
  logic               edge_wr;
  logic [4:0]         offset;
  logic               win_valid;
  logic [3:0]         win_idx;
  logic               unused_wdata;
`ifdef OTTER_INTC_PRIORITY_EN
  logic [2*NUM_SRC-1:0] prio_q, prio_d;
  logic [1:0]           thresh_q, thresh_d;
  logic [1:0]           win_prio;
`endif

  assign sel     = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign offset  = IOBUS_ADDR[4:0];
  assign wr_en   = IOBUS_WR & sel;
  assign edge_wr = wr_en && (offset == OffEdge);
  assign w1c     = (wr_en && (offset == OffPending)) ? IOBUS_OUT[NUM_SRC-1:0] : '0;

  // Write-data bits above the implemented register widths are intentionally dropped.
  assign unused_wdata = ^IOBUS_OUT;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~hist_q;
  assign act    = pending_q & enable_q;

  // Winner selection over the active set.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
`ifdef OTTER_INTC_PRIORITY_EN
    win_prio  = '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef OTTER_INTC_PRIORITY_EN
      // Strict '>' keeps a tie with the lower index that was already chosen.
      if (act[i] && (!win_valid || (prio_q[2*i +: 2] > win_prio))) begin
        win_prio  = prio_q[2*i +: 2];
`else
      if (act[i] && !win_valid) begin
`endif
        win_valid = 1'b1;
        win_idx   = 4'(i);
      end
    end
  end

  // Register next-state.
  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    gie_d    = gie_q;
`ifdef OTTER_INTC_PRIORITY_EN
    prio_d   = prio_q;
    thresh_d = thresh_q;
`endif
    if (wr_en) begin
      unique case (offset)
        OffEnable: enable_d = IOBUS_OUT[NUM_SRC-1:0];
        OffEdge:   edge_d   = IOBUS_OUT[NUM_SRC-1:0];
        OffGie:    gie_d    = IOBUS_OUT[0];
`ifdef OTTER_INTC_PRIORITY_EN
        OffPrio:   prio_d   = IOBUS_OUT[2*NUM_SRC-1:0];
        OffThresh: thresh_d = IOBUS_OUT[1:0];
`endif
        default: ;
      endcase
    end
  end

  // Pending: edge bits latch rises (a rise beats a same-cycle W1C), level bits track the
  // synchronised input. Rewriting EDGE discards whatever was pending under the old mode.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_wr) begin
        pending_d[i] = 1'b0;
      end else if (edge_q[i]) begin
        pending_d[i] = rise[i] | (pending_q[i] & ~w1c[i]);
      end else begin
        pending_d[i] = synced[i];
      end
    end
  end

  always_comb begin
`ifdef OTTER_INTC_PRIORITY_EN
    intr_d = gie_q & win_valid & (win_prio >= thresh_q);
`else
    intr_d = gie_q & win_valid;
`endif
  end

  // Read mux; registered below so reads have one cycle of latency.
  always_comb begin
    rdata_d = '0;
    if (sel) begin
      unique case (offset)
        OffPending: rdata_d = 32'(pending_q);
        OffEnable:  rdata_d = 32'(enable_q);
        OffEdge:    rdata_d = 32'(edge_q);
        OffId:      rdata_d = {win_valid, 27'd0, win_idx};
        OffGie:     rdata_d = {31'd0, gie_q};
`ifdef OTTER_INTC_PRIORITY_EN
        OffPrio:    rdata_d = 32'(prio_q);
        OffThresh:  rdata_d = {30'd0, thresh_q};
`endif
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q    <= '0;
      hist_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      gie_q     <= 1'b0;
      INTR      <= 1'b0;
      IOBUS_IN  <= '0;
`ifdef OTTER_INTC_PRIORITY_EN
      prio_q    <= '0;
      thresh_q  <= '0;
`endif
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], SRC};
      hist_q    <= synced;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      gie_q     <= gie_d;
      INTR      <= intr_d;
      IOBUS_IN  <= rdata_d;
`ifdef OTTER_INTC_PRIORITY_EN
      prio_q    <= prio_d;
      thresh_q  <= thresh_d;
`endif
    end
  end

endmodule

// File: tb/tb_otter_intc.sv
// Bench for otter_intc: directed scenarios plus a randomized phase. Read responses are
// queued at issue time and checked by a separate monitor when IOBUS_IN presents them;
// INTR is compared against a behavioural model every cycle.
module tb_otter_intc;

  localparam int NS = 8;
  localparam int SS = 2;
  localparam logic [31:0] BASE = 32'h1100_0100;

  logic          CLK;
  logic          RST_N;
  logic [NS-1:0] SRC;
  logic [31:0]   IOBUS_ADDR;
  logic [31:0]   IOBUS_OUT;
  logic          IOBUS_WR;
  logic [31:0]   IOBUS_IN;
  logic          INTR;

  otter_intc #(
    .NUM_SRC     (NS),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (SS)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SRC        (SRC),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .INTR       (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- behavioural model ----------------
  logic [NS-1:0]   m_pend = '0;
  logic [NS-1:0]   m_en   = '0;
  logic [NS-1:0]   m_edge = '0;
  logic            m_gie  = 1'b0;
  logic            m_intr = 1'b0;
  logic [2*NS-1:0] m_prio = '0;
  logic [1:0]      m_thresh = '0;
  // m_hist[j] = SRC as sampled j+1 clock edges ago.
  logic [NS-1:0]   m_hist [SS+1];

  function automatic bit selected(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  // Winning source index for an active set, -1 if none.
  function automatic int winner(input logic [NS-1:0] a);
`ifdef OTTER_INTC_PRIORITY_EN
    for (int p = 3; p >= 0; p--)
      for (int i = 0; i < NS; i++)
        if (a[i] && (int'(m_prio[2*i +: 2]) == p)) return i;
`else
    for (int i = 0; i < NS; i++)
      if (a[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic model_intr();
    int w;
    w = winner(m_pend & m_en);
    if (w < 0 || !m_gie) return 1'b0;
`ifdef OTTER_INTC_PRIORITY_EN
    if (m_prio[2*w +: 2] < m_thresh) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [NS-1:0] model_pend();
    logic [NS-1:0] r;
    logic [NS-1:0] now;
    logic [NS-1:0] prev;
    bit            wsel;
    r    = '0;
    now  = m_hist[SS-1];
    prev = m_hist[SS];
    wsel = IOBUS_WR && selected(IOBUS_ADDR);
    for (int i = 0; i < NS; i++) begin
      if (wsel && IOBUS_ADDR[4:0] == 5'h08) r[i] = 1'b0;
      else if (m_edge[i])
        r[i] = (now[i] && !prev[i]) ||
               (m_pend[i] && !(wsel && IOBUS_ADDR[4:0] == 5'h00 && IOBUS_OUT[i]));
      else r[i] = now[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int w;
    if (!selected(a)) return 32'h0;
    case (a[4:0])
      5'h00: return 32'(m_pend);
      5'h04: return 32'(m_en);
      5'h08: return 32'(m_edge);
      5'h0C: begin
        w = winner(m_pend & m_en);
        return (w < 0) ? 32'h0 : (32'h8000_0000 | 32'(w));
      end
      5'h10: return {31'd0, m_gie};
`ifdef OTTER_INTC_PRIORITY_EN
      5'h14: return 32'(m_prio);
      5'h18: return {30'd0, m_thresh};
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_pend   <= '0;
      m_en     <= '0;
      m_edge   <= '0;
      m_gie    <= 1'b0;
      m_intr   <= 1'b0;
      m_prio   <= '0;
      m_thresh <= '0;
      for (int j = 0; j <= SS; j++) m_hist[j] <= '0;
    end else begin
      cyc    <= cyc + 1;
      m_intr <= model_intr();
      m_pend <= model_pend();
      if (IOBUS_WR && selected(IOBUS_ADDR)) begin
        case (IOBUS_ADDR[4:0])
          5'h04: m_en   <= IOBUS_OUT[NS-1:0];
          5'h08: m_edge <= IOBUS_OUT[NS-1:0];
          5'h10: m_gie  <= IOBUS_OUT[0];
`ifdef OTTER_INTC_PRIORITY_EN
          5'h14: m_prio   <= IOBUS_OUT[2*NS-1:0];
          5'h18: m_thresh <= IOBUS_OUT[1:0];
`endif
          default: ;
        endcase
      end
      m_hist[0] <= SRC;
      for (int j = 1; j <= SS; j++) m_hist[j] <= m_hist[j-1];
    end
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    string       name;
    logic [31:0] exp;
    int          stamp;
  } exp_t;
  exp_t sb[$];

  always @(negedge CLK) begin
    if (RST_N) begin
      checks++;
      if (INTR !== m_intr) begin
        errors++;
        $display("FAIL intr cyc=%0d: got %b expected %b", cyc, INTR, m_intr);
      end
      if (sb.size() > 0 && sb[0].stamp + 1 <= cyc) begin
        checks++;
        if (sb[0].stamp + 1 != cyc || IOBUS_IN !== sb[0].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d: got %h expected %h", sb[0].name, cyc, IOBUS_IN, sb[0].exp);
        end
        void'(sb.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr_addr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = 32'h0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    wr_addr(BASE | 32'(off), d);
  endtask

  task automatic rd_const(input logic [4:0] off, input logic [31:0] exp, input string name);
    exp_t e;
    IOBUS_ADDR = BASE | 32'(off);
    IOBUS_WR   = 1'b0;
    e.name = name;
    e.exp = exp;
    e.stamp = cyc;
    sb.push_back(e);
    tick();
    IOBUS_ADDR = 32'h0;
  endtask

  task automatic rd_addr(input logic [31:0] a);
    exp_t e;
    IOBUS_ADDR = a;
    IOBUS_WR   = 1'b0;
    e.name = "rand_rd";
    e.exp = exp_read(a);
    e.stamp = cyc;
    sb.push_back(e);
    tick();
    IOBUS_ADDR = 32'h0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [4:0] offs [9];
    offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C, 5'h02};
    if ($urandom_range(7) == 0) return BASE ^ 32'h0000_0100;
    return BASE | 32'(offs[$urandom_range(8)]);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int op;
    RST_N      = 1'b1;
    SRC        = '0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    #3 RST_N = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    rd_const(5'h04, 32'h0, "por_enable");
    rd_const(5'h0C, 32'h0, "por_id");

    // Reset landing mid-activity.
    wr(5'h04, 32'hFF);
    wr(5'h10, 32'h1);
    SRC = 8'hFF;
    repeat (4) tick();
    chk("pre_rst_intr", 32'(INTR), 32'h1);
    rd_const(5'h04, 32'hFF, "pre_rst_enable");
    #1 RST_N = 1'b0;
    #1;
    chk("rst_intr", 32'(INTR), 32'h0);
    chk("rst_rdata", IOBUS_IN, 32'h0);
    SRC = '0;
    tick();
    RST_N = 1'b1;
    tick();
    rd_const(5'h04, 32'h0, "rst_enable");
    rd_const(5'h00, 32'h0, "rst_pending");
    rd_const(5'h10, 32'h0, "rst_gie");

    // Edge latency.
    wr(5'h08, 32'h01);
    wr(5'h04, 32'h01);
    wr(5'h10, 32'h01);
    SRC = 8'h01;
    tick();
    tick();
    chk("lat_intr_e2", 32'(INTR), 32'h0);
    tick();
    SRC = '0;
    chk("lat_intr_e3", 32'(INTR), 32'h0);
    rd_const(5'h00, 32'h01, "lat_pending_e3");
    chk("lat_intr_e4", 32'(INTR), 32'h1);
    rd_const(5'h0C, 32'h8000_0000, "lat_id");
    wr(5'h00, 32'h01);
    chk("w1c_intr_same", 32'(INTR), 32'h1);
    tick();
    chk("w1c_intr_next", 32'(INTR), 32'h0);

    // Level mode and fixed priority.
    wr(5'h08, 32'h0);
    wr(5'h04, 32'hFF);
    SRC = 8'h24;
    repeat (4) tick();
    rd_const(5'h0C, 32'h8000_0002, "lvl_id_2");
    wr(5'h00, 32'h04);
    tick();
    rd_const(5'h00, 32'h24, "lvl_w1c_noop");
    SRC = 8'h20;
    repeat (3) tick();
    rd_const(5'h0C, 32'h8000_0005, "lvl_id_5");

    // Rise and W1C landing on the same edge.
    wr(5'h08, 32'h08);
    SRC = '0;
    repeat (3) tick();
    SRC = 8'h08;
    tick();
    tick();
    wr(5'h00, 32'h08);
    rd_const(5'h00, 32'h08, "set_beats_clr");
    wr(5'h00, 32'h08);
    rd_const(5'h00, 32'h00, "edge_w1c");

    // GIE masking.
    SRC = '0;
    wr(5'h10, 32'h0);
    wr(5'h08, 32'h10);
    wr(5'h04, 32'h10);
    repeat (3) tick();
    SRC = 8'h10;
    repeat (4) tick();
    SRC = '0;
    repeat (3) tick();
    chk("gie0_intr", 32'(INTR), 32'h0);
    rd_const(5'h00, 32'h10, "gie_pending");
    wr(5'h10, 32'h1);
    chk("gie1_intr_same", 32'(INTR), 32'h0);
    tick();
    chk("gie1_intr_next", 32'(INTR), 32'h1);
    wr(5'h04, 32'h20);
    chk("dis_intr_same", 32'(INTR), 32'h1);
    tick();
    chk("dis_intr_next", 32'(INTR), 32'h0);
    rd_const(5'h00, 32'h10, "dis_pending");

`ifdef OTTER_INTC_PRIORITY_EN
    wr(5'h08, 32'h0);
    wr(5'h14, 32'h0000_000D);
    wr(5'h04, 32'h03);
    SRC = 8'h03;
    repeat (4) tick();
    rd_const(5'h0C, 32'h8000_0001, "prio_id");
    wr(5'h18, 32'h3);
    SRC = 8'h01;
    repeat (5) tick();
    chk("thresh_intr", 32'(INTR), 32'h0);
    rd_const(5'h0C, 32'h8000_0000, "thresh_id");
`else
    wr(5'h14, 32'hFFFF_FFFF);
    wr(5'h18, 32'h3);
    rd_const(5'h14, 32'h0, "prio_absent");
    rd_const(5'h18, 32'h0, "thresh_absent");
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(7) == 0) SRC = NS'($urandom);
      op = int'($urandom_range(9));
      if (op < 3) wr_addr(pick_addr(), $urandom);
      else if (op < 6) rd_addr(pick_addr());
      else tick();
    end

    SRC = '0;
    repeat (3) tick();
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_intc.md
Name: otter_intc

Overview:
- Parametrised multi-source interrupt controller for the OTTER MCU, sitting on the IOBUS as a memory-mapped peripheral.
- Generalises the MCU's single INTR input, which is gated only by CSR MIE, to NUM_SRC sources.
- Each source has its own enable, edge/level mode and pending state.
- Drives one registered INTR line into the MCU; the handler identifies the source by reading the ID register.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..16)
BASE_ADDR, 32'h1100_0100, IOBUS byte address of register offset 0x00
SYNC_STAGES, 2, synchroniser depth on each source input (>=2)

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
SRC  input  NUM_SRC  raw interrupt requests, asynchronous to CLK, active-high
IOBUS_ADDR  input  32  MCU IO address
IOBUS_OUT  input  32  MCU write data
IOBUS_WR  input  1  MCU IO write strobe
IOBUS_IN  output  32  read data to MCU
INTR  output  1  interrupt request to MCU, registered

Behaviour:
- Interface fixed: one clock CLK; reset RST_N is asynchronous, active-low. All flops clear immediately on RST_N=0, including when reset lands mid-operation.
- Reset values: INTR=0, IOBUS_IN=0, PENDING=0, ENABLE=0, EDGE=0 (level), GIE=0, synchronisers=0.
- Block selected when IOBUS_ADDR[31:5]==BASE_ADDR[31:5]; offset = IOBUS_ADDR[4:0]. Only word offsets are decoded.
- Register map:
  - 0x00 PENDING: read; write-1-to-clear, applies to edge-mode bits only.
  - 0x04 ENABLE: RW.
  - 0x08 EDGE: RW; 1 = rising-edge, 0 = level.
  - 0x0C ID: RO; bit31 = valid, bits[3:0] = index of the winning source.
  - 0x10 GIE: RW, bit0 only.
  - 0x14 PRIO: see optional feature.
- Bits above NUM_SRC read 0; writes to them are ignored. Unmapped offsets and unselected addresses read 0; writes to them are ignored.
- Reads: IOBUS_IN is registered and shows the value for the address presented on the previous cycle. It is 0 when that address was unselected.
- Writes: take effect on the CLK edge where IOBUS_WR=1 and the block is selected.
- Synchroniser: each SRC passes through SYNC_STAGES flops, then one history flop for edge detect.
- Edge mode:
  - PENDING[i] sets on a synchronised rising edge and holds until cleared by W1C.
  - A set and a W1C in the same cycle: set wins.
  - Further edges while pending are absorbed (no count).
- Level mode: PENDING[i] follows the synchronised level; W1C has no effect.
- Mode change: writing EDGE[i] clears PENDING[i] in that cycle.
- Active set: ACT = PENDING & ENABLE.
- INTR: registered, = GIE & |ACT. Updates one cycle after ACT/GIE change.
- Latency (SYNC_STAGES=2, source enabled, GIE=1): SRC rising -> PENDING set at edge 3 -> INTR=1 at edge 4.
- ID: combinational from ACT; IOBUS_IN shows it after the standard read register. Lowest index wins. With ACT=0, ID reads 0x0000_0000 (valid=0).
- Clearing the last active source drops INTR on the next edge. Disabling GIE drops INTR without losing PENDING.

Optional Feature:
- Macro: OTTER_INTC_PRIORITY_EN.
- Defined:
  - PRIO register at 0x14 holds 2 bits per source (source i at bits [2i+1:2i]; NUM_SRC<=16 fits). Reset value 0.
  - ID selects the highest PRIO value in ACT; ties go to the lowest index.
  - A further register at 0x18 THRESH (2 bits, RW, reset 0): INTR asserts only if the winner's PRIO >= THRESH.
- Undefined: 0x14 and 0x18 read 0, writes are ignored, priority is fixed lowest-index, and there is no threshold.

Test Plan:
- Reset: assert RST_N=0 mid-activity with ENABLE=0xFF and SRC=0xFF -> INTR=0 and all registers 0 immediately; after release, reading 0x04 returns 0.
- Edge latency: EDGE=0x01, ENABLE=0x01, GIE=1, pulse SRC[0] for 3 cycles -> PENDING=0x01 at edge 3, INTR=1 at edge 4, ID=0x8000_0000. Write 0x01 to 0x00 -> INTR=0 on the following edge.
- Level and priority: EDGE=0, ENABLE=0xFF, SRC[5] and SRC[2] held high -> ID=0x8000_0002. Write 0x04 to PENDING -> no change. Drop SRC[2] -> ID=0x8000_0005 within 4 cycles.
- Simultaneous set/clear: edge-mode SRC[3] rising edge synchronised in the same cycle as a W1C of bit 3 -> PENDING[3] stays 1.
- GIE masking: PENDING=0x10, ENABLE=0x10, GIE=0 -> INTR=0. Set GIE=1 -> INTR=1 next edge. Write 0x20 to ENABLE -> INTR=0 next edge; PENDING still reads 0x10.
- With OTTER_INTC_PRIORITY_EN: PRIO[1]=3, PRIO[0]=1, both active -> ID=0x8000_0001. THRESH=3 with only source 0 active -> INTR=0.
